// File: rtl/pc_sequencer_pkg.sv
// Shared opcode and state encodings for the program-counter sequencer.
package pc_sequencer_pkg;

  // Decoder opcodes; every encoding not listed behaves as OpNext.
  typedef enum logic [3:0] {
    OpNext = 4'h0,
    OpJp   = 4'h1,
    OpJs   = 4'h2,
    OpJz   = 4'h3,
    OpJnz  = 4'h4,
    OpCall = 4'h5,
    OpRet  = 4'h6,
    OpExit = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StPop    = 3'd2,
    StPopW   = 3'd3,
    StBranch = 3'd4,
    StNext   = 3'd5,
    StHalt   = 3'd6
  } state_e;

  // True when the op needs a target from the data stack (taken branch or CALL).
  function automatic logic needs_target(logic [3:0] op, logic z, logic s);
    logic taken;
    taken = 1'b0;
    case (op)
      OpJp:    taken = 1'b1;
      OpJs:    taken = s;
      OpJz:    taken = z;
      OpJnz:   taken = ~z;
      OpCall:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET: DEPTH entries of WIDTH bits, top always visible.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  // ptr counts valid entries; the write slot is ptr, the top entry is ptr-1.
  assign wr_idx  = IDX_W'(ptr);
  assign top_idx = IDX_W'(ptr - PTR_W'(1));
  assign full    = (ptr == PTR_W'(DEPTH));
  assign empty   = (ptr == '0);
  assign top     = empty ? '0 : mem[top_idx];

  // Storage and pointer; overflowing push and underflowing pop are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      ptr         <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: one step per en pulse, branch targets popped from the
// data stack, CALL/RET via an internal return stack, sticky halt on EXIT.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned INST_CAP  = 20,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned RET_DEPTH = 4,
  parameter int unsigned WRAP      = 0,
  localparam int unsigned PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          ctrl_op,
  input  logic                z_flag,
  input  logic                s_flag,
  input  logic [DATA_LEN-1:0] stk_data_out,
  output logic                stk_pop,
  output logic [PC_W-1:0]     pc,
  output logic                fin_sig,
  output logic                busy,
  output logic                err,
  output logic                halted
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(INST_CAP - 1);

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_step;
  logic            pop_d, fin_d, err_d, halted_d, busy_d;

  logic            rs_push, rs_pop, rs_full, rs_empty;
  logic [PC_W-1:0] rs_top;

  logic [31:0]     tgt_wide;
  logic            tgt_bad;
  logic [PC_W-1:0] tgt;

  ret_stack #(
    .DEPTH (RET_DEPTH),
    .WIDTH (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pc_step),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty)
  );

  // Sequential successor of pc: saturate or wrap at the last slot.
  always_comb begin
    pc_step = pc;
    if (pc < PC_LAST) begin
      pc_step = pc + PC_W'(1);
    end else if (WRAP != 0) begin
      pc_step = '0;
    end
  end

  // Range check uses the full data word so wide out-of-range values cannot alias low.
  assign tgt_wide = 32'(stk_data_out);
  assign tgt_bad  = (tgt_wide >= INST_CAP);
  assign tgt      = PC_W'(stk_data_out);

  // Next-state and registered-output values for the step FSM.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pc_d     = pc;
    pop_d    = 1'b0;
    fin_d    = 1'b0;
    err_d    = 1'b0;
    halted_d = halted;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          op_d    = ctrl_op;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (op_q == OpExit) begin
          state_d  = StHalt;
          halted_d = 1'b1;
          fin_d    = 1'b1;
        end else if (op_q == OpRet) begin
          state_d = StBranch;
        end else if (needs_target(op_q, z_flag, s_flag)) begin
          // stk_pop is high for exactly the POP cycle.
          state_d = StPop;
          pop_d   = 1'b1;
        end else begin
          state_d = StNext;
        end
      end

      StPop: begin
        state_d = StPopW;
      end

      StPopW: begin
        state_d = StBranch;
      end

      StBranch: begin
        fin_d   = 1'b1;
        state_d = StIdle;
        if (op_q == OpRet) begin
          if (rs_empty) begin
            err_d = 1'b1;
            pc_d  = pc_step;
          end else begin
            pc_d   = rs_top;
            rs_pop = 1'b1;
          end
        end else if ((op_q == OpCall) && rs_full) begin
          // Overflowing CALL degrades to a sequential step; the popped target is dropped.
          err_d = 1'b1;
          pc_d  = pc_step;
        end else if (tgt_bad) begin
          err_d = 1'b1;
        end else begin
          pc_d    = tgt;
          rs_push = (op_q == OpCall);
        end
      end

      StNext: begin
        pc_d    = pc_step;
        fin_d   = 1'b1;
        state_d = StIdle;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = !((state_d == StIdle) || (state_d == StHalt));
  end

  // State and all outputs are registered; reset aborts any step in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNext;
      pc      <= '0;
      stk_pop <= 1'b0;
      fin_sig <= 1'b0;
      err     <= 1'b0;
      halted  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc      <= pc_d;
      stk_pop <= pop_d;
      fin_sig <= fin_d;
      err     <= err_d;
      halted  <= halted_d;
      busy    <= busy_d;
    end
  end

endmodule
